// File: rtl/rv32i_fetch_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32i_fetch_unit_pkg : shared types and constants for the rv32i fetch stage
// Revision: 1.0
// ---------------------------------------------------------------------------
package rv32i_fetch_unit_pkg;

  typedef enum logic [1:0] {
    BRANCH_NONE     = 2'd0,
    BRANCH_RELATIVE = 2'd1,
    BRANCH_ABSOLUTE = 2'd2
  } branch_type_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4,
    FAULT = 3'd5
  } fetch_state_e;

  localparam int unsigned INST_BYTES = 4;

  function automatic logic is_misaligned(input logic [31:0] i_addr);
    return i_addr[1:0] != 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_fetch_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32i_fetch_unit_if : execute-outcome, imem and decode buses of fetch
// Revision: 1.0
// ---------------------------------------------------------------------------
interface rv32i_fetch_unit_if;
  import rv32i_fetch_unit_pkg::*;

  logic         ex_valid;
  branch_type_e ex_branch_type;
  logic [31:0]  ex_pc;
  logic [31:0]  ex_imm;
  logic [31:0]  ex_target;

  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_req_addr;
  logic         imem_resp_valid;
  logic [31:0]  imem_resp_data;

  logic         inst_valid;
  logic         inst_ready;
  logic [31:0]  inst_pc;
  logic [31:0]  inst_data;

  logic         fault;

  modport master (
    input  ex_valid, ex_branch_type, ex_pc, ex_imm, ex_target,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, fault
  );

  modport slave (
    output ex_valid, ex_branch_type, ex_pc, ex_imm, ex_target,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, fault
  );

endinterface
`default_nettype wire

// File: rtl/rv32i_fetch_target.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32i_fetch_target : resolves redirect target and alignment from execute
// Revision: 1.0
// ---------------------------------------------------------------------------
module rv32i_fetch_target
  import rv32i_fetch_unit_pkg::*;
(
  input  branch_type_e i_branch_type,
  input  logic [31:0]  i_ex_pc,
  input  logic [31:0]  i_ex_imm,
  input  logic [31:0]  i_ex_target,
  output logic         o_redirect,
  output logic [31:0]  o_target,
  output logic         o_misaligned
);

  always_comb begin
    o_redirect = 1'b0;
    o_target   = 32'h0;
    case (i_branch_type)
      BRANCH_RELATIVE: begin
        o_redirect = 1'b1;
        o_target   = i_ex_pc + i_ex_imm;
      end
      BRANCH_ABSOLUTE: begin
        o_redirect = 1'b1;
        o_target   = i_ex_target;
      end
      default: ;
    endcase
  end

  assign o_misaligned = o_redirect && is_misaligned(o_target);

endmodule
`default_nettype wire

// File: rtl/rv32i_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32i_fetch_unit : single-outstanding instruction fetch with PC redirect
// Revision: 1.0
// ---------------------------------------------------------------------------
module rv32i_fetch_unit
  import rv32i_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  rv32i_fetch_unit_if.master bus
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic         r_fault;
  logic [31:0]  r_buf_pc;
  logic [31:0]  r_buf_data;

  logic         w_redirect_raw;
  logic [31:0]  w_target;
  logic         w_misaligned;
  logic         w_redirect;
  logic         w_capture;
  logic         w_req_valid;
  logic         w_inst_valid;
  logic         w_req_hs;

  rv32i_fetch_target u_target (
    .i_branch_type (bus.ex_branch_type),
    .i_ex_pc       (bus.ex_pc),
    .i_ex_imm      (bus.ex_imm),
    .i_ex_target   (bus.ex_target),
    .o_redirect    (w_redirect_raw),
    .o_target      (w_target),
    .o_misaligned  (w_misaligned)
  );

  assign w_redirect = bus.ex_valid && w_redirect_raw;
  assign w_req_hs   = w_req_valid && bus.imem_req_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_fault    <= 1'b0;
      r_buf_pc   <= 32'h0;
      r_buf_data <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_state_nxt == FAULT) begin
        r_fault <= 1'b1;
      end
      if (w_capture) begin
        r_buf_pc   <= r_pc;
        r_buf_data <= bus.imem_resp_data;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_capture    = 1'b0;
    w_req_valid  = 1'b0;
    w_inst_valid = 1'b0;
    case (r_state)
      IDLE: w_state_nxt = REQ;
      REQ: begin
        w_req_valid = 1'b1;
        if (w_redirect) begin
          if (w_misaligned) begin
            w_state_nxt = FAULT;
          end else begin
            w_pc_nxt    = w_target;
            // An accepted request still owes a response that must be drained
            w_state_nxt = bus.imem_req_ready ? DRAIN : REQ;
          end
        end else if (bus.imem_req_ready) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (w_redirect) begin
          if (w_misaligned) begin
            w_state_nxt = FAULT;
          end else begin
            w_pc_nxt    = w_target;
            w_state_nxt = bus.imem_resp_valid ? REQ : DRAIN;
          end
        end else if (bus.imem_resp_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = HOLD;
        end
      end
      DRAIN: begin
        if (w_redirect && w_misaligned) begin
          w_state_nxt = FAULT;
        end else begin
          if (w_redirect) begin
            w_pc_nxt = w_target;
          end
          // The owed response can coincide with a redirect; leaving then avoids waiting forever
          if (bus.imem_resp_valid) begin
            w_state_nxt = REQ;
          end
        end
      end
      HOLD: begin
        w_inst_valid = 1'b1;
        if (w_redirect) begin
          if (w_misaligned) begin
            w_state_nxt = FAULT;
          end else begin
            w_pc_nxt    = w_target;
            w_state_nxt = REQ;
          end
        end else if (bus.inst_ready) begin
          w_pc_nxt    = r_pc + 32'(INST_BYTES);
          w_state_nxt = REQ;
        end
      end
      FAULT: w_state_nxt = FAULT;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.inst_valid     = w_inst_valid;
  assign bus.inst_pc        = r_buf_pc;
  assign bus.inst_data      = r_buf_data;
  assign bus.fault          = r_fault;

endmodule
`default_nettype wire
